if_fetch_unit: RTL

- Instruction-fetch stage of the 4-stage pipelined processor; it is the producer side of the IF/ID pipeline register.
- Holds the program counter, a small writable instruction memory and a run-control FSM.
- Each cycle it presents one 8-bit instruction on ins_out, which feeds the IF/ID register input.
- Handles stall, branch redirect (with wrong-path squash) and halt.

---
 rtl/if_pkg.sv | 15 +
 rtl/if_instr_mem.sv | 24 ++
 rtl/if_fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Provides the run-control state enum and the default opcode/width constants.
package if_pkg;

    localparam int AW_DEF = 4;
    localparam logic [7:0] NOP_DEF = 8'h00;
    localparam logic [7:0] HALT_DEF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_instr_mem.sv
// Instruction store: 2**AW x 8 words, synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
module if_instr_mem #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC, instruction store and IDLE/RUN/HALT run control.
// Ports: clk, reset (sync, active-low), start, prog_we/prog_addr/prog_data,
//   stall, redirect/redirect_addr -> ins_out, pc_out, fetch_valid, halted.
// Optional: IF_FETCH_CNT_EN adds fetch_cnt[15:0] (saturating fetch count).
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int         AW        = AW_DEF,
    parameter logic [7:0] NOP_CODE  = NOP_DEF,
    parameter logic [7:0] HALT_CODE = HALT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [7:0]    prog_data,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic [7:0]    ins_out,
    output logic [AW-1:0] pc_out,
    output logic          fetch_valid,
    output logic          halted
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [15:0]   fetch_cnt
`endif
);

    if_state_e     state;
    logic [AW-1:0] pc;
    logic [7:0]    rd_data;
    logic          mem_we;

    // Programming only in IDLE, and never on a reset edge.
    assign mem_we = reset && (state == IDLE) && prog_we;

    if_instr_mem #(.AW(AW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (rd_data)
    );

    // A taken branch squashes the word fetched this cycle.
    always_comb begin
        ins_out     = NOP_CODE;
        fetch_valid = 1'b0;
        if (state == RUN && !redirect) begin
            ins_out     = rd_data;
            fetch_valid = 1'b1;
        end
    end

    assign pc_out = pc;
    assign halted = (state == HALT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        pc <= redirect_addr;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (rd_data == HALT_CODE) begin
                        state <= HALT;
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                    pc    <= '0;
                end
            endcase
        end
    end

`ifdef IF_FETCH_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt <= '0;
        end else if (state == RUN && fetch_valid && !stall
                     && fetch_cnt != 16'hFFFF) begin
            fetch_cnt <= fetch_cnt + 16'd1;
        end
    end
`endif

endmodule
